cache_tag_store: RTL and testbench

- 4-way set-associative, write-back tag/data/LRU store.
- Sits directly downstream of the cache controller FSM. It consumes the FSM's one-hot-ish control strobes c0..c7 and returns the hit, miss and full status the FSM branches on.
- Holds valid/dirty/tag/data per way, true-LRU ages per set, and emits dirty victims toward the memory side.

---
 rtl/cache_tag_store.sv | 215 +++++++++++++++++++++
 tb/tb_cache_tag_store.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_tag_store.sv
// 4-way set-associative write-back tag/data/LRU store driven by the cache controller strobes.
// Returns registered hit/miss, a combinational set-full flag and one-cycle dirty-victim pulses.
module cache_tag_store #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned INDEX_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] wdata_in,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              c0,
   input  logic              c1,
   input  logic              c2,
   input  logic              c3,
   input  logic              c4,
   input  logic              c5,
   input  logic              c6,
   input  logic              c7,
   output logic              hit,
   output logic              miss,
   output logic              full,
   output logic [DATA_W-1:0] rdata,
   output logic              evict_valid,
   output logic [ADDR_W-1:0] evict_addr,
   output logic [DATA_W-1:0] evict_data
);

   localparam int SETS  = 2 ** INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W;
   localparam int WAYS  = 4;

   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   dirty_q [SETS];
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [DATA_W-1:0] data_q  [SETS][WAYS];
   logic [1:0]        age_q   [SETS][WAYS];

   logic [ADDR_W-1:0] req_addr_q;
   logic [DATA_W-1:0] req_wdata_q;
   logic              req_wr_q;
   logic              lookup_done_q;
   logic              miss_pending_q;
   logic              hit_q;
   logic              miss_q;
   logic [1:0]        hit_way_q;
   logic [DATA_W-1:0] rdata_q;
   logic              evict_valid_q;
   logic [ADDR_W-1:0] evict_addr_q;
   logic [DATA_W-1:0] evict_data_q;

   logic [INDEX_W-1:0] lk_set;
   logic [TAG_W-1:0]   lk_tag;
   logic [INDEX_W-1:0] req_set;
   logic [TAG_W-1:0]   req_tag;
   logic               lookup;
   logic [WAYS-1:0]    lk_match;
   logic               lk_hit;
   logic [1:0]         lk_way;
   logic [1:0]         victim_way;
   logic [1:0]         free_way;
   logic               do_hit;
   logic               do_evict;
   logic               do_fill;
   logic               touch_en;
   logic [1:0]         touch_way;
   logic [1:0]         touch_age;

   // CHECK is purely informational for this block.
   logic unused_check;
   assign unused_check = c5;

   assign lk_set  = addr_in[INDEX_W-1:0];
   assign lk_tag  = addr_in[ADDR_W-1:INDEX_W];
   assign req_set = req_addr_q[INDEX_W-1:0];
   assign req_tag = req_addr_q[ADDR_W-1:INDEX_W];

   // One lookup per request: lookup_done blocks re-triggering while c1/c2 stay high.
   assign lookup = (c1 | c2) & ~c3 & ~c4 & ~lookup_done_q;
   assign full   = &valid_q[req_set];

   always_comb begin
      lk_match = '0;
      lk_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         lk_match[w] = valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag);
         if (lk_match[w]) lk_way = 2'(w);
      end
      lk_hit = |lk_match;
   end

   always_comb begin
      victim_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (age_q[req_set][w] == 2'd3) victim_way = 2'(w);
      end
   end

   // Descending scan leaves the lowest-index invalid way selected.
   always_comb begin
      free_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[req_set][w]) free_way = 2'(w);
      end
   end

   assign do_hit    = c3 & hit_q;
   assign do_evict  = c7 & ~do_hit & full;
   assign do_fill   = c6 & ~do_hit & ~do_evict & miss_pending_q & ~full;
   assign touch_en  = do_hit | do_fill;
   assign touch_way = do_hit ? hit_way_q : free_way;
   assign touch_age = age_q[req_set][touch_way];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               age_q[s][w] <= 2'(w);
            end
         end
         req_addr_q     <= '0;
         req_wdata_q    <= '0;
         req_wr_q       <= 1'b0;
         lookup_done_q  <= 1'b0;
         miss_pending_q <= 1'b0;
         hit_q          <= 1'b0;
         miss_q         <= 1'b0;
         hit_way_q      <= '0;
         rdata_q        <= '0;
         evict_valid_q  <= 1'b0;
         evict_addr_q   <= '0;
         evict_data_q   <= '0;
      end else begin
         evict_valid_q <= 1'b0;

         if (lookup) begin
            req_addr_q  <= addr_in;
            req_wdata_q <= wdata_in;
            req_wr_q    <= c2 & ~c1;
            hit_q       <= lk_hit;
            miss_q      <= ~lk_hit;
            hit_way_q   <= lk_way;
         end else if (c0 | c3 | c4) begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
         end

         if (c0) begin
            lookup_done_q <= 1'b0;
         end else if (lookup) begin
            lookup_done_q <= 1'b1;
         end

         if (c4) begin
            miss_pending_q <= 1'b1;
         end else if (do_fill) begin
            miss_pending_q <= 1'b0;
         end

         if (do_hit) begin
            if (req_wr_q) begin
               data_q[req_set][hit_way_q]  <= req_wdata_q;
               dirty_q[req_set][hit_way_q] <= 1'b1;
            end else begin
               rdata_q <= data_q[req_set][hit_way_q];
            end
         end

         if (do_evict) begin
            valid_q[req_set][victim_way] <= 1'b0;
            dirty_q[req_set][victim_way] <= 1'b0;
            if (dirty_q[req_set][victim_way]) begin
               evict_valid_q <= 1'b1;
               evict_addr_q  <= {tag_q[req_set][victim_way], req_set};
               evict_data_q  <= data_q[req_set][victim_way];
            end
         end

         if (do_fill) begin
            tag_q[req_set][free_way]   <= req_tag;
            valid_q[req_set][free_way] <= 1'b1;
            if (req_wr_q) begin
               data_q[req_set][free_way]  <= req_wdata_q;
               dirty_q[req_set][free_way] <= 1'b1;
            end else begin
               data_q[req_set][free_way]  <= mem_rdata;
               dirty_q[req_set][free_way] <= 1'b0;
               rdata_q                    <= mem_rdata;
            end
         end

         // Ages younger than the touched way shift up by one; ages stay a permutation.
         if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
               if (2'(w) == touch_way) begin
                  age_q[req_set][w] <= 2'd0;
               end else if (age_q[req_set][w] < touch_age) begin
                  age_q[req_set][w] <= age_q[req_set][w] + 2'd1;
               end
            end
         end
      end
   end

   assign hit         = hit_q;
   assign miss        = miss_q;
   assign rdata       = rdata_q;
   assign evict_valid = evict_valid_q;
   assign evict_addr  = evict_addr_q;
   assign evict_data  = evict_data_q;

endmodule

// File: tb/tb_cache_tag_store.sv
// Bench for cache_tag_store: directed controller sequences, a recency-list cache model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_cache_tag_store;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr_in;
   logic [31:0] wdata_in;
   logic [31:0] mem_rdata;
   logic        c0, c1, c2, c3, c4, c5, c6, c7;
   logic        hit, miss, full, evict_valid;
   logic [31:0] rdata, evict_data;
   logic [15:0] evict_addr;

   cache_tag_store dut (
      .clk         (clk),
      .rst         (rst),
      .addr_in     (addr_in),
      .wdata_in    (wdata_in),
      .mem_rdata   (mem_rdata),
      .c0          (c0),
      .c1          (c1),
      .c2          (c2),
      .c3          (c3),
      .c4          (c4),
      .c5          (c5),
      .c6          (c6),
      .c7          (c7),
      .hit         (hit),
      .miss        (miss),
      .full        (full),
      .rdata       (rdata),
      .evict_valid (evict_valid),
      .evict_addr  (evict_addr),
      .evict_data  (evict_data)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   // Model: per-line records and a most-recent-first way list per set.
   bit          m_v    [8][4];
   bit          m_d    [8][4];
   int          m_tag  [8][4];
   logic [31:0] m_data [8][4];
   int          rec    [8][4];
   int          m_req_addr;
   logic [31:0] m_req_wdata;
   bit          m_req_wr;
   bit          m_done, m_pend, m_hit, m_miss, m_ev;
   int          m_hit_way;
   logic [31:0] m_rdata, m_ed;
   int          m_ea;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit model_full();
      int s = m_req_addr % 8;
      return m_v[s][0] && m_v[s][1] && m_v[s][2] && m_v[s][3];
   endfunction

   task automatic touch(input int s, input int k);
      int p = 0;
      for (int i = 0; i < 4; i++) if (rec[s][i] == k) p = i;
      for (int i = p; i > 0; i--) rec[s][i] = rec[s][i-1];
      rec[s][0] = k;
   endtask

   task automatic model_step();
      int  s, t, sl, tl, lkway, w;
      bit  lk, lkhit, was_full;
      if (rst) begin
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 4; j++) begin
               m_v[i][j] = 0; m_d[i][j] = 0; rec[i][j] = j;
            end
         m_req_addr = 0; m_req_wdata = '0; m_req_wr = 0;
         m_done = 0; m_pend = 0; m_hit = 0; m_miss = 0; m_hit_way = 0;
         m_rdata = '0; m_ev = 0; m_ea = 0; m_ed = '0;
         return;
      end
      s  = m_req_addr % 8;
      t  = m_req_addr / 8;
      sl = int'(addr_in) % 8;
      tl = int'(addr_in) / 8;
      lk = (c1 || c2) && !c3 && !c4 && !m_done;
      lkhit = 0; lkway = 0;
      for (int j = 0; j < 4; j++)
         if (m_v[sl][j] && m_tag[sl][j] == tl) begin lkhit = 1; lkway = j; end
      was_full = model_full();
      m_ev = 0;
      if (c3 && m_hit) begin
         if (m_req_wr) begin
            m_data[s][m_hit_way] = m_req_wdata; m_d[s][m_hit_way] = 1;
         end else begin
            m_rdata = m_data[s][m_hit_way];
         end
         touch(s, m_hit_way);
      end else if (c7 && was_full) begin
         w = rec[s][3];
         if (m_d[s][w]) begin m_ev = 1; m_ea = m_tag[s][w] * 8 + s; m_ed = m_data[s][w]; end
         m_v[s][w] = 0; m_d[s][w] = 0;
      end else if (c6 && m_pend && !was_full) begin
         w = 0;
         for (int j = 3; j >= 0; j--) if (!m_v[s][j]) w = j;
         m_v[s][w] = 1; m_tag[s][w] = t;
         if (m_req_wr) begin
            m_data[s][w] = m_req_wdata; m_d[s][w] = 1;
         end else begin
            m_data[s][w] = mem_rdata; m_d[s][w] = 0; m_rdata = mem_rdata;
         end
         touch(s, w);
         m_pend = 0;
      end
      if (c4) m_pend = 1;
      if (lk) begin
         m_hit = lkhit; m_miss = !lkhit; m_hit_way = lkway;
         m_req_addr = int'(addr_in); m_req_wdata = wdata_in; m_req_wr = c2 && !c1;
      end else if (c0 || c3 || c4) begin
         m_hit = 0; m_miss = 0;
      end
      if (c0) m_done = 0;
      else if (lk) m_done = 1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            chk("cyc_hit", 32'(hit), 32'(m_hit));
            chk("cyc_miss", 32'(miss), 32'(m_miss));
            chk("cyc_full", 32'(full), 32'(model_full()));
            chk("cyc_rdata", rdata, m_rdata);
            chk("cyc_evict_valid", 32'(evict_valid), 32'(m_ev));
            if (m_ev) begin
               chk("cyc_evict_addr", 32'(evict_addr), 32'(m_ea));
               chk("cyc_evict_data", evict_data, m_ed);
            end
         end
      end
   end

   task automatic access(input logic [15:0] a, input bit wr, input logic [31:0] wd,
                         input logic [31:0] fill, output bit o_hit, output bit o_miss,
                         output bit o_full, output bit o_ev, output logic [15:0] o_ea,
                         output logic [31:0] o_ed, output logic [31:0] o_rdata);
      o_ev = 0; o_ea = '0; o_ed = '0;
      c0 = 1; tick(); c0 = 0;
      addr_in = a; wdata_in = wd; c1 = !wr; c2 = wr;
      tick();
      o_hit = hit; o_miss = miss; o_full = full;
      tick();
      c1 = 0; c2 = 0;
      if (m_hit) begin
         c3 = 1; tick(); c3 = 0;
      end else begin
         c4 = 1; tick(); c4 = 0;
         c5 = 1; tick(); o_full = full; c5 = 0;
         if (model_full()) begin
            c7 = 1; tick();
            o_ev = evict_valid; o_ea = evict_addr; o_ed = evict_data;
            c7 = 0;
         end
         mem_rdata = fill; c6 = 1; tick(); c6 = 0;
      end
      o_rdata = rdata;
   endtask

   initial begin
      bit          h, m, f, ev;
      logic [15:0] ea;
      logic [31:0] ed, rd;
      int          cnt;
      rst = 1; addr_in = '0; wdata_in = '0; mem_rdata = '0;
      {c0, c1, c2, c3, c4, c5, c6, c7} = '0;
      repeat (3) tick();
      rst = 0;
      chk_on = 1;
      chk("reset_hit", 32'(hit), 32'd0);
      chk("reset_miss", 32'(miss), 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_evict", 32'(evict_valid), 32'd0);
      chk("reset_full", 32'(full), 32'd0);

      access(16'h0012, 0, '0, 32'hA5A5_0001, h, m, f, ev, ea, ed, rd);
      chk("first_miss", 32'(m), 32'd1);
      chk("first_full", 32'(f), 32'd0);
      chk("first_fill_rdata", rd, 32'hA5A5_0001);

      access(16'h0012, 0, '0, '0, h, m, f, ev, ea, ed, rd);
      chk("second_hit", 32'(h), 32'd1);
      chk("second_rdata", rd, 32'hA5A5_0001);
      chk("second_no_evict", 32'(ev), 32'd0);

      access(16'h0012, 1, 32'h1234_5678, '0, h, m, f, ev, ea, ed, rd);
      chk("write_hit", 32'(h), 32'd1);
      access(16'h0012, 0, '0, '0, h, m, f, ev, ea, ed, rd);
      chk("readback_write", rd, 32'h1234_5678);

      access(16'h0022, 0, '0, 32'h2222_0000, h, m, f, ev, ea, ed, rd);
      access(16'h0032, 0, '0, 32'h3333_0000, h, m, f, ev, ea, ed, rd);
      access(16'h0042, 0, '0, 32'h4444_0000, h, m, f, ev, ea, ed, rd);
      chk("fourth_fill_rdata", rd, 32'h4444_0000);
      access(16'h0052, 0, '0, 32'h5555_0000, h, m, f, ev, ea, ed, rd);
      chk("evict_miss", 32'(m), 32'd1);
      chk("evict_full", 32'(f), 32'd1);
      chk("evict_pulse", 32'(ev), 32'd1);
      chk("evict_addr", 32'(ea), 32'h0012);
      chk("evict_data", ed, 32'h1234_5678);
      chk("refill_rdata", rd, 32'h5555_0000);

      // Request held for five cycles: exactly one lookup, result held until c3.
      c0 = 1; tick(); c0 = 0;
      addr_in = 16'h0022; c1 = 1; cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         cnt += int'(hit);
      end
      chk("hold_hit_cycles", 32'(cnt), 32'd5);
      c1 = 0; c3 = 1; tick(); c3 = 0;
      chk("hold_rdata", rdata, 32'h2222_0000);
      chk("hold_cleared", 32'(hit), 32'd0);

      access(16'h0012, 0, '0, 32'h1111_0000, h, m, f, ev, ea, ed, rd);
      chk("clean_victim_miss", 32'(m), 32'd1);
      chk("clean_victim_no_pulse", 32'(ev), 32'd0);

      access(16'h0064, 1, 32'hCAFE_F00D, 32'hBAD0_0000, h, m, f, ev, ea, ed, rd);
      chk("wmiss_rdata_kept", rd, 32'h1111_0000);
      access(16'h0064, 0, '0, '0, h, m, f, ev, ea, ed, rd);
      chk("wmiss_readback", rd, 32'hCAFE_F00D);

      // Reset during CHECK after a miss discards the request.
      c0 = 1; tick(); c0 = 0;
      addr_in = 16'h0013; c1 = 1; tick();
      chk("pre_reset_miss", 32'(miss), 32'd1);
      c1 = 0; c4 = 1; tick(); c4 = 0;
      c5 = 1; tick();
      rst = 1; tick(); rst = 0; c5 = 0;
      chk("rst_mid_hit", 32'(hit), 32'd0);
      chk("rst_mid_miss", 32'(miss), 32'd0);
      chk("rst_mid_rdata", rdata, 32'd0);
      chk("rst_mid_full", 32'(full), 32'd0);
      mem_rdata = 32'hDEAD_BEEF; c6 = 1; tick(); c6 = 0;
      chk("stray_fill_ignored", rdata, 32'd0);
      access(16'h0013, 0, '0, 32'h1313_0000, h, m, f, ev, ea, ed, rd);
      chk("no_alloc_after_reset", 32'(m), 32'd1);
      access(16'h0022, 0, '0, 32'h2020_0000, h, m, f, ev, ea, ed, rd);
      chk("reset_cleared_valid", 32'(m), 32'd1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
